controller_port_responder: RTL and testbench



---
 rtl/controller_port_responder.sv | 122 ++++++++++++
 tb/tb_controller_port_responder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/controller_port_responder.sv
// controller_port_responder
// Answers CPU reads of $4016/$4017 with one serial button bit per read from
// two standard 8-button pads. Button state is parallel-loaded while the pad
// strobe (OUT0) is high and shifted once per completed read while it is low.
module controller_port_responder #(
   parameter logic [7:0] OPEN_BUS_BITS = 8'h40,
   parameter int         SYNC_STAGES   = 2
) (
   input  logic       clock,
   input  logic       nreset,
   input  logic       naddr4016r,
   input  logic       naddr4017r,
   input  logic [2:0] addr4016w,
   input  logic [7:0] buttons1,
   input  logic [7:0] buttons2,
   output logic [7:0] data_out,
   output logic       data_oe,
   output logic [2:0] out_latch
);

   // Synchronizer chains for the raw pad inputs; the last stage is the
   // value the shift registers load from.
   logic [7:0] sync1_pipe [SYNC_STAGES];
   logic [7:0] sync2_pipe [SYNC_STAGES];
   logic [7:0] sync1;
   logic [7:0] sync2;

   // Serial shift registers, one per pad; bit 0 is the next bit returned.
   logic [7:0] sr1;
   logic [7:0] sr2;

   // Registered strobe level and previous read-strobe levels.
   logic       strobe_q;
   logic       r16_q;
   logic       r17_q;

   // A read completes when the active-low strobe returns high.
   logic       done16;
   logic       done17;

   assign sync1  = sync1_pipe[SYNC_STAGES-1];
   assign sync2  = sync2_pipe[SYNC_STAGES-1];
   assign done16 = naddr4016r & ~r16_q;
   assign done17 = naddr4017r & ~r17_q;

   // Move raw button levels through the synchronizer stages.
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync1_pipe[i] <= 8'h00;
            sync2_pipe[i] <= 8'h00;
         end
      end else begin
         sync1_pipe[0] <= buttons1;
         sync2_pipe[0] <= buttons2;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync1_pipe[i] <= sync1_pipe[i-1];
            sync2_pipe[i] <= sync2_pipe[i-1];
         end
      end
   end

   // Capture the CPU's OUT latch level and the pad strobe bit every clock.
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         out_latch <= 3'b000;
         strobe_q  <= 1'b0;
      end else begin
         out_latch <= addr4016w;
         strobe_q  <= addr4016w[0];
      end
   end

   // Remember last clock's read-strobe levels so each read is seen once;
   // reset parks them high so a strobe released after reset cannot shift.
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         r16_q <= 1'b1;
         r17_q <= 1'b1;
      end else begin
         r16_q <= naddr4016r;
         r17_q <= naddr4017r;
      end
   end

   // Pad 1 shifter: load wins over shift; ones fill in from the top so an
   // exhausted pad reads back 1.
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         sr1 <= 8'h00;
      end else if (strobe_q) begin
         sr1 <= sync1;
      end else if (done16) begin
         sr1 <= {1'b1, sr1[7:1]};
      end
   end

   // Pad 2 shifter, independent of pad 1.
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         sr2 <= 8'h00;
      end else if (strobe_q) begin
         sr2 <= sync2;
      end else if (done17) begin
         sr2 <= {1'b1, sr2[7:1]};
      end
   end

   // Drive the CPU data-in mux while a read strobe is low; $4016 has priority.
   always_comb begin
      data_out = 8'h00;
      data_oe  = 1'b0;
      if (!naddr4016r) begin
         data_out = {OPEN_BUS_BITS[7:1], sr1[0]};
         data_oe  = 1'b1;
      end else if (!naddr4017r) begin
         data_out = {OPEN_BUS_BITS[7:1], sr2[0]};
         data_oe  = 1'b1;
      end
   end

endmodule

// File: tb/tb_controller_port_responder.sv
// tb_controller_port_responder
// Scoreboard bench: the stimulus side pushes the expected read value for each
// read it issues; a monitor pops and compares whenever the DUT starts driving
// the bus. The reference model treats each pad as a snapshot plus a read count.
module tb_controller_port_responder;

   localparam int         S  = 2;
   localparam logic [7:0] OB = 8'h40;

   logic       clock = 1'b0;
   logic       nreset;
   logic       naddr4016r;
   logic       naddr4017r;
   logic [2:0] addr4016w;
   logic [7:0] buttons1;
   logic [7:0] buttons2;
   logic [7:0] data_out;
   logic       data_oe;
   logic [2:0] out_latch;

   int         checks = 0;
   int         passed = 0;
   int         cyc = 0;
   logic [7:0] ob_v = OB;

   logic [7:0] hist1 [4096];
   logic [7:0] hist2 [4096];
   logic [7:0] exp_q [$];

   logic [7:0] snap [2];
   int         reads [2];
   logic       strobe_on = 1'b0;
   logic       prev_oe = 1'b0;

   controller_port_responder #(
      .OPEN_BUS_BITS(OB),
      .SYNC_STAGES(S)
   ) dut (
      .clock(clock),
      .nreset(nreset),
      .naddr4016r(naddr4016r),
      .naddr4017r(naddr4017r),
      .addr4016w(addr4016w),
      .buttons1(buttons1),
      .buttons2(buttons2),
      .data_out(data_out),
      .data_oe(data_oe),
      .out_latch(out_latch)
   );

   // Free-running clock.
   always #5 clock = ~clock;

   task automatic checkOutput(input string nm, input logic [8:0] act, input logic [8:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   task automatic tick();
      @(posedge clock);
      cyc++;
      #1;
   endtask

   // Record the button levels that the next rising edge will sample.
   always @(negedge clock) begin
      hist1[(cyc + 1) & 4095] = buttons1;
      hist2[(cyc + 1) & 4095] = buttons2;
   end

   // Monitor: compare each new bus ownership against the scoreboard, and
   // require a quiet bus whenever no read strobe is low.
   always @(negedge clock) begin
      if (nreset) begin
         if (data_oe && !prev_oe) begin
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_read", {data_oe, data_out}, 9'h000);
            end else begin
               checkOutput("read_data", {data_oe, data_out}, {1'b1, exp_q.pop_front()});
            end
         end
         if (naddr4016r && naddr4017r)
            checkOutput("idle_bus", {data_oe, data_out}, 9'h000);
      end
      prev_oe = data_oe;
   end

   function automatic void modelReset();
      snap[0]  = 8'h00;
      snap[1]  = 8'h00;
      reads[0] = 0;
      reads[1] = 0;
   endfunction

   // One CPU read: port 0 = $4016, 1 = $4017, 2 = both strobes (illegal, $4016 wins).
   task automatic applyStimulus(input int port, input int lowlen);
      int   p;
      logic b;
      p = (port == 1) ? 1 : 0;
      if (strobe_on)
         b = (p == 0) ? hist1[(cyc - S) & 4095][0] : hist2[(cyc - S) & 4095][0];
      else
         b = (reads[p] < 8) ? snap[p][reads[p]] : 1'b1;
      exp_q.push_back({ob_v[7:1], b});
      if (port != 1) naddr4016r = 1'b0;
      if (port != 0) naddr4017r = 1'b0;
      repeat (lowlen) tick();
      naddr4016r = 1'b1;
      naddr4017r = 1'b1;
      tick();
      if (!strobe_on) begin
         if (port != 1) reads[0]++;
         if (port != 0) reads[1]++;
      end
   endtask

   // Raise the pad strobe, optionally read (and toggle A) while it is high,
   // then let the pads settle and drop the strobe, taking the snapshot.
   task automatic strobePulse(input int nreads, input bit toggle_a, input int gap);
      addr4016w = {2'($urandom_range(0, 3)), 1'b1};
      tick();
      checkOutput("out_latch", {6'd0, out_latch}, {6'd0, addr4016w});
      tick();
      strobe_on = 1'b1;
      for (int i = 0; i < nreads; i++) begin
         if (toggle_a) buttons1[0] = ~buttons1[0];
         repeat (gap) tick();
         applyStimulus(int'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
      end
      repeat (S + 2) tick();
      snap[0]  = buttons1;
      snap[1]  = buttons2;
      reads[0] = 0;
      reads[1] = 0;
      addr4016w[0] = 1'b0;
      tick();
      strobe_on = 1'b0;
      tick();
      checkOutput("out_latch_low", {6'd0, out_latch}, {6'd0, addr4016w});
   endtask

   // Watchdog so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      nreset     = 1'b0;
      naddr4016r = 1'b1;
      naddr4017r = 1'b1;
      addr4016w  = 3'b000;
      buttons1   = 8'h00;
      buttons2   = 8'h00;
      modelReset();
      #12;
      checkOutput("reset_bus", {data_oe, data_out}, 9'h000);
      checkOutput("reset_out_latch", {6'd0, out_latch}, 9'h000);
      nreset = 1'b1;
      tick();

      // Twelve reads straight out of reset: eight zeros then ones.
      for (int i = 0; i < 12; i++) applyStimulus(0, 1);

      // Known pattern on pad 1, ten reads past exhaustion.
      buttons1 = 8'b1000_0101;
      repeat (4) tick();
      strobePulse(0, 1'b0, 0);
      for (int i = 0; i < 10; i++) applyStimulus(0, 1);

      // Strobe held with A toggling: reads follow the lagged A level.
      strobePulse(6, 1'b1, 4);
      for (int i = 0; i < 9; i++) applyStimulus(0, 1);

      // Long read pulses still shift once each.
      buttons1 = 8'($urandom);
      strobePulse(0, 1'b0, 0);
      for (int i = 0; i < 8; i++) applyStimulus(0, 6);

      // Pad 2 Up only, interleaved with pad 1.
      buttons1 = 8'h00;
      buttons2 = 8'h10;
      strobePulse(0, 1'b0, 0);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(0, 1);
         applyStimulus(1, 1);
      end

      // Reset in the middle of a read while the strobe is high.
      buttons1 = 8'hff;
      strobePulse(0, 1'b0, 0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 1);
      addr4016w = 3'b111;
      tick();
      tick();
      naddr4016r = 1'b0;
      nreset     = 1'b0;
      #1;
      checkOutput("midreset_out_latch", {6'd0, out_latch}, 9'h000);
      checkOutput("midreset_data", {data_oe, data_out}, {1'b1, 8'h40});
      naddr4016r = 1'b1;
      addr4016w  = 3'b000;
      #1;
      nreset = 1'b1;
      modelReset();
      tick();
      for (int i = 0; i < 10; i++) applyStimulus(0, 1);

      // Randomized transactions.
      for (int it = 0; it < 40; it++) begin
         buttons1 = 8'($urandom);
         buttons2 = 8'($urandom);
         repeat ($urandom_range(0, 3)) tick();
         strobePulse(int'($urandom_range(0, 3)), 1'($urandom), int'($urandom_range(0, 4)));
         for (int r = 0; r < int'($urandom_range(0, 12)); r++) begin
            applyStimulus(($urandom_range(0, 9) == 0) ? 2 : int'($urandom_range(0, 1)),
                          int'($urandom_range(1, 6)));
            repeat ($urandom_range(0, 2)) tick();
         end
      end

      repeat (4) tick();
      checkOutput("scoreboard_drained", 9'(exp_q.size()), 9'd0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
